// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM driver family.
package pwm_pkg;

  localparam int PWM_VAL_W = 10;
  localparam logic [PWM_VAL_W-1:0] PWM_VAL_MAX = 10'd1023;

  typedef enum logic [1:0] {
    IDLE,
    MEAS_HI,
    MEAS_LO
  } pwm_cap_state_t;

endpackage

// File: rtl/cdc_sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs, reset to 0.
module cdc_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/drv_pwm_cap_10b.sv
// PWM input capture: measures high width and rise-to-rise period of an async pin,
// reports a saturated 10-bit duty value per period and flags a stuck pin.
module drv_pwm_cap_10b #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_drv_port,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_period_cnt,
  output logic [9:0]       o_val,
  output logic             o_valid,
  output logic             o_timeout
);
  import pwm_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] VAL_CAP = CNT_W'(PWM_VAL_MAX);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + CNT_ONE;
  endfunction

  logic s2, s3;
  logic [2:0] warm;
  logic rise, fall, timeout_hit;
  pwm_cap_state_t state, state_nxt;
  logic [CNT_W-1:0] hcnt, pcnt, hlat, icnt;
  logic [CNT_W-1:0] hcnt_nxt, pcnt_nxt, hlat_nxt, icnt_nxt;
  logic [CNT_W-1:0] high_nxt, period_nxt;
  logic [9:0] val_nxt;
  logic valid_nxt, timeout_nxt;

  cdc_sync_2ff u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_drv_port),
    .q   (s2)
  );

  // Edges are ignored until s3 holds a real pin sample; otherwise a pin that is
  // high across reset would look like a fresh rise and publish a partial period.
  assign rise = warm[2] & s2 & ~s3;
  assign fall = warm[2] & ~s2 & s3;
  assign timeout_hit = ~(rise | fall) && (icnt == TO_LAST);

  always_comb begin
    state_nxt   = state;
    hcnt_nxt    = hcnt;
    pcnt_nxt    = pcnt;
    hlat_nxt    = hlat;
    high_nxt    = o_high_cnt;
    period_nxt  = o_period_cnt;
    val_nxt     = o_val;
    valid_nxt   = 1'b0;
    timeout_nxt = o_timeout;
    icnt_nxt    = (rise | fall) ? '0 : sat_inc(icnt);

    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEAS_HI;
          hcnt_nxt  = CNT_ONE;
          pcnt_nxt  = CNT_ONE;
        end
      end
      MEAS_HI: begin
        pcnt_nxt = sat_inc(pcnt);
        if (fall) begin
          state_nxt = MEAS_LO;
          hlat_nxt  = hcnt;
        end else begin
          hcnt_nxt = sat_inc(hcnt);
        end
      end
      MEAS_LO: begin
        if (rise) begin
          state_nxt   = MEAS_HI;
          high_nxt    = hlat;
          period_nxt  = pcnt;
          val_nxt     = (hlat > VAL_CAP) ? PWM_VAL_MAX : hlat[PWM_VAL_W-1:0];
          valid_nxt   = 1'b1;
          timeout_nxt = 1'b0;
          hcnt_nxt    = CNT_ONE;
          pcnt_nxt    = CNT_ONE;
        end else begin
          pcnt_nxt = sat_inc(pcnt);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Fires once: the idle counter passes TO_LAST and keeps counting while stuck.
    if (timeout_hit) begin
      state_nxt   = IDLE;
      high_nxt    = '0;
      period_nxt  = '0;
      val_nxt     = s2 ? PWM_VAL_MAX : '0;
      valid_nxt   = 1'b1;
      timeout_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s3           <= 1'b0;
      warm         <= '0;
      state        <= IDLE;
      hcnt         <= '0;
      pcnt         <= '0;
      hlat         <= '0;
      icnt         <= '0;
      o_high_cnt   <= '0;
      o_period_cnt <= '0;
      o_val        <= '0;
      o_valid      <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      s3           <= s2;
      warm         <= {warm[1:0], 1'b1};
      state        <= state_nxt;
      hcnt         <= hcnt_nxt;
      pcnt         <= pcnt_nxt;
      hlat         <= hlat_nxt;
      icnt         <= icnt_nxt;
      o_high_cnt   <= high_nxt;
      o_period_cnt <= period_nxt;
      o_val        <= val_nxt;
      o_valid      <= valid_nxt;
      o_timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_drv_pwm_cap_10b.sv
// Directed bench for drv_pwm_cap_10b: periodic vectors from a table plus
// hand-written latency, timeout and reset sequences.
module tb_drv_pwm_cap_10b;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 4096;
  // Pin change to timeout strobe: 2 sync stages + 1 edge register + TIMEOUT counts.
  localparam int TO_LAT  = TIMEOUT + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pin = 1'b0;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic [9:0]       val;
  logic             valid, timeout;

  int tests = 0;
  int fails = 0;
  int vcount = 0;
  int cap_h, cap_p, cap_v, cap_to;

  drv_pwm_cap_10b #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_drv_port   (pin),
    .o_high_cnt   (high_cnt),
    .o_period_cnt (period_cnt),
    .o_val        (val),
    .o_valid      (valid),
    .o_timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      vcount = vcount + 1;
      cap_h  = int'(high_cnt);
      cap_p  = int'(period_cnt);
      cap_v  = int'(val);
      cap_to = int'(timeout);
    end
  end

  typedef struct {
    int high;
    int period;
    int n;
    int exp_h;
    int exp_p;
    int exp_v;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lvl, input int n);
    pin = lvl;
    tick(n);
  endtask

  task automatic do_reset();
    pin = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
  endtask

  // Counts posedges until a strobe (optionally a timeout strobe) is seen, bounded.
  task automatic wait_valid(input bit need_to, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(posedge clk);
      #1;
      n++;
      if (valid && (!need_to || timeout)) break;
    end
  endtask

  initial begin
    int v0;
    int n;

    vecs[0] = '{high: 256,  period: 1024, n: 3, exp_h: 256,  exp_p: 1024, exp_v: 256};
    vecs[1] = '{high: 255,  period: 1024, n: 2, exp_h: 255,  exp_p: 1024, exp_v: 255};
    vecs[2] = '{high: 1500, period: 2000, n: 2, exp_h: 1500, exp_p: 2000, exp_v: 1023};
    vecs[3] = '{high: 1,    period: 2,    n: 4, exp_h: 1,    exp_p: 2,    exp_v: 1};
    vecs[4] = '{high: 1023, period: 1100, n: 1, exp_h: 1023, exp_p: 1100, exp_v: 1023};
    vecs[5] = '{high: 1024, period: 1100, n: 1, exp_h: 1024, exp_p: 1100, exp_v: 1023};
    vecs[6] = '{high: 5,    period: 6,    n: 3, exp_h: 5,    exp_p: 6,    exp_v: 5};

    // Reset state
    tick(3);
    check("rst_high", int'(high_cnt), 0);
    check("rst_period", int'(period_cnt), 0);
    check("rst_val", int'(val), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_timeout", int'(timeout), 0);

    // Periodic vectors: n full periods closed by a final rise
    for (int i = 0; i < 7; i++) begin
      do_reset();
      v0 = vcount;
      for (int k = 0; k < vecs[i].n; k++) begin
        drive(1'b1, vecs[i].high);
        drive(1'b0, vecs[i].period - vecs[i].high);
      end
      drive(1'b1, 8);
      check($sformatf("v%0d_count", i), vcount - v0, vecs[i].n);
      check($sformatf("v%0d_high", i), cap_h, vecs[i].exp_h);
      check($sformatf("v%0d_period", i), cap_p, vecs[i].exp_p);
      check($sformatf("v%0d_val", i), cap_v, vecs[i].exp_v);
      check($sformatf("v%0d_timeout", i), cap_to, 0);
    end

    // Rise-to-strobe latency
    do_reset();
    drive(1'b1, 10);
    drive(1'b0, 10);
    pin = 1'b1;
    wait_valid(1'b0, 10, n);
    check("latency", n, 3);
    tick(4);

    // Stuck high then stuck low
    do_reset();
    drive(1'b1, 10);
    drive(1'b0, 10);
    v0 = vcount;
    pin = 1'b1;
    wait_valid(1'b1, 5000, n);
    check("to_hi_latency", n, TO_LAT);
    check("to_hi_flag", int'(timeout), 1);
    check("to_hi_val", int'(val), 1023);
    check("to_hi_high", int'(high_cnt), 0);
    check("to_hi_period", int'(period_cnt), 0);
    tick(900);
    check("to_hi_pulses", vcount - v0, 2);

    v0 = vcount;
    pin = 1'b0;
    wait_valid(1'b1, 5000, n);
    check("to_lo_latency", n, TO_LAT);
    check("to_lo_val", int'(val), 0);
    check("to_lo_flag", int'(timeout), 1);
    tick(900);
    check("to_lo_pulses", vcount - v0, 1);

    // Recovery: flag holds through the first rise, clears at the next publish
    drive(1'b1, 20);
    check("to_hold_flag", int'(timeout), 1);
    drive(1'b0, 30);
    check("to_hold_pulses", vcount - v0, 1);
    drive(1'b1, 8);
    check("rec_pulses", vcount - v0, 2);
    check("rec_flag", int'(timeout), 0);
    check("rec_high", cap_h, 20);
    check("rec_period", cap_p, 50);
    check("rec_val", cap_v, 20);

    // Reset mid-high discards the partial measurement
    do_reset();
    drive(1'b1, 100);
    drive(1'b0, 100);
    drive(1'b1, 48);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("mid_rst_high", int'(high_cnt), 0);
    check("mid_rst_period", int'(period_cnt), 0);
    check("mid_rst_val", int'(val), 0);
    check("mid_rst_valid", int'(valid), 0);
    v0 = vcount;
    drive(1'b1, 50);
    drive(1'b0, 150);
    drive(1'b1, 60);
    drive(1'b0, 90);
    check("mid_rst_no_pulse", vcount - v0, 0);
    drive(1'b1, 8);
    check("mid_rst_pulse", vcount - v0, 1);
    check("mid_rst_cap_high", cap_h, 60);
    check("mid_rst_cap_period", cap_p, 150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
